// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : registered integer arithmetic/logic unit (execute-stage datapath)
//
// Operands and opcode are sampled on every rising clock edge. When valid_in
// is high the selected function of (op, a, b) is captured into r, so a result
// appears exactly one cycle after its operands. When valid_in is low, r keeps
// its previous value. valid_out is valid_in delayed by one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (r and valid_out cleared)
//   a          operand A
//   b          operand B, also the full-width shift amount
//   op         operation select (see OP_* below)
//   valid_in   operands/op valid this cycle
//   r          registered result
//   valid_out  r holds a new result this cycle
// ---------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             valid_in,
    output logic [WIDTH-1:0] r,
    output logic             valid_out
);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_NOT    = 4'd7;
    localparam logic [3:0] OP_SHL    = 4'd8;
    localparam logic [3:0] OP_SHR    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_INC    = 4'd11;
    localparam logic [3:0] OP_DEC    = 4'd12;
    localparam logic [3:0] OP_POPCNT = 4'd13;

    localparam int SH_BITS = $clog2(WIDTH);
    localparam int PC_W    = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] r_reg;
    logic             valid_reg;

    // The shift amount is the whole of b. Anything at or beyond WIDTH shifts
    // every bit out; below that, the low SH_BITS bits carry the full value.
    logic               shift_big;
    logic [SH_BITS-1:0] shift_amt;

    assign shift_big = (b >= WIDTH_V);
    assign shift_amt = b[SH_BITS-1:0];

    // Population count of a, zero-extended to the result width.
    logic [PC_W-1:0] pop_cnt;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + PC_W'(a[i]);
        end
    end

    // Quotient with divide-by-zero forced to all ones.
    logic [WIDTH-1:0] div_q;

    always_comb begin
        div_q = '1;
        if (b != '0) begin
            div_q = a / b;
        end
    end

    always_comb begin
        result_next = '0;
        case (op)
            OP_ADD:    result_next = a + b;
            OP_SUB:    result_next = a - b;
            OP_MUL:    result_next = a * b;
            OP_DIV:    result_next = div_q;
            OP_AND:    result_next = a & b;
            OP_OR:     result_next = a | b;
            OP_XOR:    result_next = a ^ b;
            OP_NOT:    result_next = ~a;
            OP_SHL:    result_next = shift_big ? '0 : (a << shift_amt);
            OP_SHR:    result_next = shift_big ? '0 : (a >> shift_amt);
            OP_SRA:    result_next = shift_big ? {WIDTH{a[WIDTH-1]}}
                                               : WIDTH'($signed(a) >>> shift_amt);
            OP_INC:    result_next = a + WIDTH'(1);
            OP_DEC:    result_next = a - WIDTH'(1);
            OP_POPCNT: result_next = {{(WIDTH-PC_W){1'b0}}, pop_cnt};
            default:   result_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_in;
            if (valid_in) begin
                r_reg <= result_next;
            end
        end
    end

    assign r         = r_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : directed self-checking bench for alu
// Each operation is driven on the falling edge and its registered result is
// sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        valid_in;
    logic [31:0] r;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .valid_in  (valid_in),
        .r         (r),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, expv);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // One valid operation; result checked one cycle later.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] expv);
        @(negedge clk);
        op       = o;
        a        = av;
        b        = bv;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " r"}, r, expv);
        check({tag, " valid"}, {31'd0, valid_out}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        valid_in = 1'b0;

        // Reset state, held across edges.
        #1;
        check("reset r", r, 32'd0);
        check("reset valid", {31'd0, valid_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset hold r", r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle r", r, 32'd0);
        check("idle valid", {31'd0, valid_out}, 32'd0);

        // Arithmetic (back-to-back, one op per cycle).
        run_op("ADD",      4'd0,  32'h10, 32'd5, 32'h15);
        run_op("SUB",      4'd1,  32'h10, 32'd5, 32'h0B);
        run_op("MUL",      4'd2,  32'h10, 32'd5, 32'h50);
        run_op("DIV",      4'd3,  32'h20, 32'd5, 32'h6);
        run_op("DIV0",     4'd3,  32'd5,  32'd0, 32'hFFFF_FFFF);
        run_op("SUB wrap", 4'd1,  32'd0,  32'd1, 32'hFFFF_FFFF);
        run_op("MUL trunc",4'd2,  32'h0001_0001, 32'h0001_0000, 32'h0001_0000);

        // Logic.
        run_op("AND",  4'd4,  32'hF0, 32'h0F, 32'h0);
        run_op("OR",   4'd5,  32'hF0, 32'h0F, 32'hFF);
        run_op("XOR",  4'd6,  32'hF0, 32'h0F, 32'hFF);
        run_op("NOT",  4'd7,  32'hFFFF_FFFF, 32'h1234, 32'h0);
        run_op("NOT2", 4'd7,  32'h0F0F_0000, 32'h0, 32'hF0F0_FFFF);
        run_op("RSV14",4'd14, 32'h1234, 32'h5678, 32'h0);
        run_op("RSV15",4'd15, 32'h1234, 32'h5678, 32'h0);

        // Shifts, including amounts beyond the width.
        run_op("SHL",     4'd8,  32'd1,          32'd5,  32'h20);
        run_op("SHR",     4'd9,  32'h20,         32'd2,  32'h8);
        run_op("SRA",     4'd10, 32'hFFFF_FFF0,  32'd1,  32'hFFFF_FFF8);
        run_op("SRA pos", 4'd10, 32'h4000_0000,  32'd4,  32'h0400_0000);
        run_op("SHR 40",  4'd9,  32'h8000_0000,  32'd40, 32'h0);
        run_op("SRA 40",  4'd10, 32'h8000_0000,  32'd40, 32'hFFFF_FFFF);
        run_op("SHL 40",  4'd8,  32'h8000_0000,  32'd40, 32'h0);
        run_op("SHL 31",  4'd8,  32'd1,          32'd31, 32'h8000_0000);
        run_op("SHR 32",  4'd9,  32'hFFFF_FFFF,  32'd32, 32'h0);

        // Unary.
        run_op("INC",      4'd11, 32'hA,         32'h99, 32'hB);
        run_op("DEC",      4'd12, 32'hA,         32'h99, 32'h9);
        run_op("INC wrap", 4'd11, 32'hFFFF_FFFF, 32'h0,  32'h0);
        run_op("DEC wrap", 4'd12, 32'h0,         32'h0,  32'hFFFF_FFFF);
        run_op("POP FF",   4'd13, 32'hFF,        32'h0,  32'd8);
        run_op("POP all",  4'd13, 32'hFFFF_FFFF, 32'h0,  32'd32);
        run_op("POP zero", 4'd13, 32'h0,         32'hFF, 32'd0);
        run_op("POP mix",  4'd13, 32'h8000_0001, 32'h0,  32'd2);

        // valid_in low with changing operands: result held.
        run_op("pre hold", 4'd0, 32'h100, 32'h23, 32'h123);
        @(negedge clk);
        valid_in = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1;
        @(posedge clk);
        #1;
        check("hold r", r, 32'h123);
        check("hold valid", {31'd0, valid_out}, 32'd0);

        // Reset pulse mid-stream, asserted between edges.
        run_op("pre rst", 4'd6, 32'hFFFF_0000, 32'h00FF_00FF, 32'hFF00_00FF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst r", r, 32'd0);
        check("async rst valid", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        valid_in = 1'b1;
        op       = 4'd0;
        a        = 32'd7;
        b        = 32'd7;
        @(posedge clk);
        #1;
        check("rst held r", r, 32'd0);
        check("rst held valid", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("post rst idle r", r, 32'd0);
        check("post rst idle valid", {31'd0, valid_out}, 32'd0);
        run_op("resume ADD", 4'd0, 32'd7, 32'd7, 32'd14);
        run_op("resume SUB", 4'd1, 32'd7, 32'd9, 32'hFFFF_FFFE);

        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("end valid", {31'd0, valid_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
